// File: rtl/cordic_engine.sv
// Fully pipelined CORDIC: per-sample rotate/vector mode, valid/tag sidebands, saturated outputs.
// One sample per clock, latency ITERATIONS+1 clocks.
module cordic_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITERATIONS  = 16,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_valid,
    input  logic                   i_mode,
    input  logic [DATA_WIDTH-1:0]  i_x,
    input  logic [DATA_WIDTH-1:0]  i_y,
    input  logic [ANGLE_WIDTH-1:0] i_angle,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_x,
    output logic [DATA_WIDTH-1:0]  o_y,
    output logic [ANGLE_WIDTH-1:0] o_angle,
    output logic [TAG_WIDTH-1:0]   o_tag
);
    localparam int IW = DATA_WIDTH + 2;
    localparam int unsigned ASH = 32 - ANGLE_WIDTH;
    localparam logic [ANGLE_WIDTH-1:0] QUARTER     = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};
    localparam logic [ANGLE_WIDTH-1:0] NEG_QUARTER = {2'b11, {(ANGLE_WIDTH-2){1'b0}}};
    localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    // atan(2^-i) in 2^32-per-turn units, rounded to ANGLE_WIDTH bits
    function automatic logic [ANGLE_WIDTH-1:0] atan_lut(input int unsigned i);
        logic [31:0] t;
        logic [32:0] raw;
        case (i)
            0:  t = 32'h20000000;  1:  t = 32'h12E4051E;  2:  t = 32'h09FB385B;
            3:  t = 32'h051111D4;  4:  t = 32'h028B0D43;  5:  t = 32'h0145D7E1;
            6:  t = 32'h00A2F62E;  7:  t = 32'h00517C55;  8:  t = 32'h0028BE53;
            9:  t = 32'h00145F2F;  10: t = 32'h000A2F98;  11: t = 32'h000517CC;
            12: t = 32'h00028BE6;  13: t = 32'h000145F3;  14: t = 32'h0000A2FA;
            15: t = 32'h0000517D;  16: t = 32'h000028BE;  17: t = 32'h0000145F;
            18: t = 32'h00000A30;  19: t = 32'h00000518;  20: t = 32'h0000028C;
            21: t = 32'h00000146;  22: t = 32'h000000A3;  23: t = 32'h00000051;
            24: t = 32'h00000029;  25: t = 32'h00000014;  26: t = 32'h0000000A;
            27: t = 32'h00000005;  28: t = 32'h00000003;  29: t = 32'h00000001;
            30: t = 32'h00000001;  default: t = '0;
        endcase
        raw = {1'b0, t} + ((33'd1 << ASH) >> 1);
        raw = raw >> ASH;
        return raw[ANGLE_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] h;
        h = v >>> 1;
        if (h > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
        else if (h < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        else                  return h[DATA_WIDTH-1:0];
    endfunction

    logic signed [IW-1:0]    x_q [ITERATIONS];
    logic signed [IW-1:0]    y_q [ITERATIONS];
    logic [ANGLE_WIDTH-1:0]  z_q [ITERATIONS];
    logic                    v_q [ITERATIONS];
    logic                    m_q [ITERATIONS];
    logic                    zero_q [ITERATIONS];
    logic [TAG_WIDTH-1:0]    t_q [ITERATIONS];

    logic signed [IW-1:0]    x_d [ITERATIONS+1];
    logic signed [IW-1:0]    y_d [ITERATIONS+1];
    logic [ANGLE_WIDTH-1:0]  z_d [ITERATIONS+1];

    logic signed [IW-1:0]    xe, ye, xs, ys;
    logic                    dpos;

    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   xo_q, yo_q, xo_d, yo_d;
    logic [ANGLE_WIDTH-1:0]  ang_q, ang_d;
    logic [TAG_WIDTH-1:0]    tag_q;

    always_comb begin
        xe   = {{2{i_x[DATA_WIDTH-1]}}, i_x};
        ye   = {{2{i_y[DATA_WIDTH-1]}}, i_y};
        xs   = '0;
        ys   = '0;
        dpos = 1'b0;
        for (int unsigned k = 0; k <= ITERATIONS; k++) begin
            x_d[k] = '0;
            y_d[k] = '0;
            z_d[k] = '0;
        end

        x_d[0] = xe;
        y_d[0] = ye;
        z_d[0] = i_angle;
        if (i_mode) begin
            z_d[0] = '0;
            if (xe[IW-1] && !ye[IW-1]) begin
                x_d[0] = ye;
                y_d[0] = -xe;
                z_d[0] = QUARTER;
            end else if (xe[IW-1]) begin
                x_d[0] = -ye;
                y_d[0] = xe;
                z_d[0] = NEG_QUARTER;
            end
        end else begin
            case (i_angle[ANGLE_WIDTH-1 -: 2])
                2'b01: begin
                    x_d[0] = -ye;
                    y_d[0] = xe;
                    z_d[0] = {2'b00, i_angle[ANGLE_WIDTH-3:0]};
                end
                2'b10: begin
                    x_d[0] = ye;
                    y_d[0] = -xe;
                    z_d[0] = {2'b11, i_angle[ANGLE_WIDTH-3:0]};
                end
                default: ;
            endcase
        end

        for (int unsigned k = 0; k < ITERATIONS; k++) begin
            xs   = x_q[k] >>> k;
            ys   = y_q[k] >>> k;
            dpos = m_q[k] ? y_q[k][IW-1] : ~z_q[k][ANGLE_WIDTH-1];
            if (dpos) begin
                x_d[k+1] = x_q[k] - ys;
                y_d[k+1] = y_q[k] + xs;
                z_d[k+1] = z_q[k] - atan_lut(k);
            end else begin
                x_d[k+1] = x_q[k] + ys;
                y_d[k+1] = y_q[k] - xs;
                z_d[k+1] = z_q[k] + atan_lut(k);
            end
        end

        xo_d  = saturate(x_d[ITERATIONS]);
        yo_d  = saturate(y_d[ITERATIONS]);
        // a zero vector never turns, so its accumulated phase is meaningless: report 0
        ang_d = (m_q[ITERATIONS-1] && zero_q[ITERATIONS-1]) ? '0 : z_d[ITERATIONS];
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int unsigned k = 0; k < ITERATIONS; k++) begin
                x_q[k]    <= '0;
                y_q[k]    <= '0;
                z_q[k]    <= '0;
                v_q[k]    <= 1'b0;
                m_q[k]    <= 1'b0;
                zero_q[k] <= 1'b0;
                t_q[k]    <= '0;
            end
            valid_q <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            ang_q   <= '0;
            tag_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < ITERATIONS; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                z_q[k] <= z_d[k];
            end
            v_q[0]    <= i_valid;
            m_q[0]    <= i_mode;
            zero_q[0] <= (i_x == '0) && (i_y == '0);
            t_q[0]    <= i_tag;
            for (int unsigned k = 1; k < ITERATIONS; k++) begin
                v_q[k]    <= v_q[k-1];
                m_q[k]    <= m_q[k-1];
                zero_q[k] <= zero_q[k-1];
                t_q[k]    <= t_q[k-1];
            end
            valid_q <= v_q[ITERATIONS-1];
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            ang_q   <= ang_d;
            tag_q   <= t_q[ITERATIONS-1];
        end
    end

    assign o_valid = valid_q;
    assign o_x     = xo_q;
    assign o_y     = yo_q;
    assign o_angle = ang_q;
    assign o_tag   = tag_q;
endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: directed corner cases, random mixed-mode traffic, mid-stream reset.
module tb_cordic_engine;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int IT  = 16;
    localparam int TW  = 4;
    localparam int LAT = IT + 1;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          iv = 1'b0;
    logic          im = 1'b0;
    logic [DW-1:0] ix = '0;
    logic [DW-1:0] iy = '0;
    logic [AW-1:0] ia = '0;
    logic [TW-1:0] itg = '0;
    logic          ov;
    logic [DW-1:0] ox, oy;
    logic [AW-1:0] oa;
    logic [TW-1:0] otg;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        longint      ex;
        longint      ey;
        longint      ez;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int unsigned nsent = 0;
    real         gain;

    cordic_engine #(
        .DATA_WIDTH (DW),
        .ANGLE_WIDTH(AW),
        .ITERATIONS (IT),
        .TAG_WIDTH  (TW)
    ) dut (
        .i_clk   (clk),
        .i_resetn(rstn),
        .i_valid (iv),
        .i_mode  (im),
        .i_x     (ix),
        .i_y     (iy),
        .i_angle (ia),
        .i_tag   (itg),
        .o_valid (ov),
        .o_x     (ox),
        .o_y     (oy),
        .o_angle (oa),
        .o_tag   (otg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp,
                         input longint tol, input bit wrap);
        longint d;
        logic [31:0] w;
        d = got - exp;
        if (wrap) begin
            w = d[31:0];
            d = longint'($signed(w));
        end
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, exp, tol);
        end
    endtask

    function automatic longint clampr(input real v);
        longint r;
        r = longint'(v);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model(input bit mode, input int x, input int y, input logic [31:0] a,
                         output longint ex, output longint ey, output longint ez);
        real ar;
        if (!mode) begin
            ar = real'($signed(a)) * 2.0 * PI / 4294967296.0;
            ex = clampr(gain * (real'(x) * $cos(ar) - real'(y) * $sin(ar)));
            ey = clampr(gain * (real'(x) * $sin(ar) + real'(y) * $cos(ar)));
            ez = 0;
        end else begin
            ex = clampr(gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
            ey = 0;
            ez = longint'($atan2(real'(y), real'(x)) / (2.0 * PI) * 4294967296.0);
        end
    endtask

    task automatic push_sample(input bit mode, input int x, input int y, input logic [31:0] a,
                               input longint ex, input longint ey, input longint ez);
        exp_t e;
        @(posedge clk);
        #1;
        iv  = 1'b1;
        im  = mode;
        ix  = 16'(x);
        iy  = 16'(y);
        ia  = a;
        itg = 4'(nsent);
        e.due = cyc + LAT;
        e.tag = 4'(nsent);
        e.ex  = ex;
        e.ey  = ey;
        e.ez  = ez;
        sb.push_back(e);
        nsent++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iv  = 1'b0;
            im  = 1'($urandom);
            ix  = 16'($urandom);
            iy  = 16'($urandom);
            ia  = $urandom;
            itg = 4'($urandom);
        end
    endtask

    task automatic random_sample(input bit mode);
        int x, y;
        logic [31:0] a;
        longint ex, ey, ez;
        a = $urandom;
        if (mode) begin
            x = int'($urandom_range(0, 40000)) - 20000;
            y = int'($urandom_range(0, 40000)) - 20000;
            if ((x < 0 ? -x : x) + (y < 0 ? -y : y) < 12000)
                x = (x < 0) ? x - 12000 : x + 12000;
        end else begin
            x = int'($urandom_range(0, 60000)) - 30000;
            y = int'($urandom_range(0, 60000)) - 30000;
        end
        model(mode, x, y, a, ex, ey, ez);
        push_sample(mode, x, y, a, ex, ey, ez);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("latency_miss", longint'(cyc), longint'(sb[0].due), 0, 1'b0);
                void'(sb.pop_front());
            end
            if (ov) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0, 0, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", longint'(cyc), longint'(mon_e.due), 0, 1'b0);
                    check("tag", longint'(otg), longint'(mon_e.tag), 0, 1'b0);
                    check("x", longint'($signed(ox)), mon_e.ex, 4, 1'b0);
                    check("y", longint'($signed(oy)), mon_e.ey, 4, 1'b0);
                    check("angle", longint'(oa), mon_e.ez, 262144, 1'b1);
                end
            end
        end
    end

    initial begin
        bit md;
        gain = 1.0;
        for (int i = 0; i < IT; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        gain = gain / 2.0;

        @(negedge clk);
        check("rst_valid", longint'(ov), 0, 0, 1'b0);
        check("rst_x", longint'(ox), 0, 0, 1'b0);
        check("rst_y", longint'(oy), 0, 0, 1'b0);
        check("rst_angle", longint'(oa), 0, 0, 1'b0);
        check("rst_tag", longint'(otg), 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        push_sample(1'b0, 16384, 0, 32'h20000000, 9539, 9539, 0);
        push_sample(1'b0, 10000, 0, 32'h80000000, -8234, 0, 0);
        push_sample(1'b0, 10000, 0, 32'h40000000, 0, 8234, 0);
        push_sample(1'b1, 0, -10000, 32'h0, 8234, 0, 64'hC0000000);
        push_sample(1'b1, -10000, 0, 32'h0, 8234, 0, 64'h80000000);
        push_sample(1'b1, 32767, 32767, 32'h0, 32767, 0, 64'h20000000);
        push_sample(1'b1, 0, 0, 32'h12345678, 0, 0, 0);
        push_sample(1'b0, -32768, -32768, 32'h0, -26981, -26981, 0);
        idle(3);

        md = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 60) begin
                md = ~md;
                random_sample(md);
            end else begin
                idle(1);
            end
        end
        idle(LAT + 3);

        for (int n = 0; n < 5; n++) random_sample(n[0]);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        iv   = 1'b0;
        sb.delete();
        #1;
        check("async_rst_valid", longint'(ov), 0, 0, 1'b0);
        check("async_rst_x", longint'(ox), 0, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("hold_rst_valid", longint'(ov), 0, 0, 1'b0);
            check("hold_rst_x", longint'(ox), 0, 0, 1'b0);
            check("hold_rst_y", longint'(oy), 0, 0, 1'b0);
            check("hold_rst_angle", longint'(oa), 0, 0, 1'b0);
            check("hold_rst_tag", longint'(otg), 0, 0, 1'b0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(5);
        for (int n = 0; n < 6; n++) random_sample(n[0]);
        idle(LAT + 5);

        check("drain", longint'(sb.size()), 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
